// File: rtl/bootram_seq_pkg.sv
// Shared types and constants for the boot BRAM sequencer: FSM states, grant IDs,
// access latencies and a byte-lane helper.
package bootram_seq_pkg;

    localparam int LANES  = 4;
    localparam int RD_LAT = 6;
    localparam int WR_LAT = 5;
    localparam int LD_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CPU_RD,
        CPU_WR,
        LD_WR,
        DONE
    } state_t;

    typedef enum logic {
        CPU    = 1'b0,
        LOADER = 1'b1
    } grant_t;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bootram_seq_ctrl_if.sv
// Requester-side bus of the boot BRAM sequencer: the PicoRV32 native bus plus the
// byte-wide boot loader write port.
interface bootram_seq_ctrl_if #(
    parameter int ADDR_W = 11
);

    logic              mem_valid;
    logic              mem_ready;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb, ld_valid, ld_addr, ld_data,
        input  mem_ready, mem_rdata, ld_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb, ld_valid, ld_addr, ld_data,
        output mem_ready, mem_rdata, ld_ready
    );

endinterface

// File: rtl/bootram_rr_arb.sv
// Two-way round-robin arbiter between the CPU and the boot loader; grants are
// only issued while arb_en is high and last_grant remembers who won last.
module bootram_rr_arb
    import bootram_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic req_cpu,
    input  logic req_ld,
    output logic gnt_cpu,
    output logic gnt_ld
);

    grant_t last_grant;

    // On a tie the requester that did not win last time gets the BRAM.
    always_comb begin
        gnt_cpu = arb_en && req_cpu && (!req_ld || (last_grant == LOADER));
        gnt_ld  = arb_en && req_ld && (!req_cpu || (last_grant == CPU));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= LOADER;
        end else if (gnt_cpu) begin
            last_grant <= CPU;
        end else if (gnt_ld) begin
            last_grant <= LOADER;
        end
    end

endmodule

// File: rtl/bootram_seq_ctrl.sv
// Splits 32-bit CPU accesses into four byte-lane cycles on the 2Kx8 boot BRAM and
// shares the BRAM with the UART loader. Loader port enabled by `BOOTRAM_LOADER_EN.
module bootram_seq_ctrl
    import bootram_seq_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    bootram_seq_ctrl_if.slave bus,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    output logic              busy
);

    state_t            state, state_n;
    logic [2:0]        step, step_n;
    logic [ADDR_W-3:0] word_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              ram_ce_n, ram_wre_n;
    logic [ADDR_W-1:0] ram_ad_n;
    logic [7:0]        ram_din_n;
    logic              mem_ready_q, mem_ready_n;
    logic              ld_ready_q, ld_ready_n;
    logic [31:0]       rdata_q, rdata_n;
    logic              ld_req, arb_en, gnt_cpu, gnt_ld;
    logic [1:0]        next_lane, cap_lane;

`ifdef BOOTRAM_LOADER_EN
    assign ld_req = bus.ld_valid;
`else
    assign ld_req = 1'b0;
`endif

    assign arb_en = (state == IDLE);

    bootram_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .arb_en  (arb_en),
        .req_cpu (bus.mem_valid),
        .req_ld  (ld_req),
        .gnt_cpu (gnt_cpu),
        .gnt_ld  (gnt_ld)
    );

    // step counts cycles inside a CPU access; reads capture a lane two edges after issuing it.
    assign next_lane = step[1:0] + 2'd1;
    assign cap_lane  = step[1:0] - 2'd1;

    always_comb begin
        state_n     = state;
        step_n      = step;
        ram_ce_n    = 1'b0;
        ram_wre_n   = 1'b0;
        ram_ad_n    = ram_ad;
        ram_din_n   = ram_din;
        mem_ready_n = 1'b0;
        ld_ready_n  = 1'b0;
        rdata_n     = rdata_q;
        case (state)
            IDLE: begin
                step_n = 3'd0;
                if (gnt_cpu) begin
                    ram_ad_n = {bus.mem_addr[ADDR_W-1:2], 2'd0};
                    if (bus.mem_wstrb == 4'b0000) begin
                        state_n  = CPU_RD;
                        ram_ce_n = 1'b1;
                    end else begin
                        state_n   = CPU_WR;
                        ram_ce_n  = bus.mem_wstrb[0];
                        ram_wre_n = bus.mem_wstrb[0];
                        ram_din_n = lane_byte(bus.mem_wdata, 2'd0);
                    end
                end else if (gnt_ld) begin
                    state_n   = LD_WR;
                    ram_ce_n  = 1'b1;
                    ram_wre_n = 1'b1;
                    ram_ad_n  = bus.ld_addr;
                    ram_din_n = bus.ld_data;
                end
            end
            CPU_RD: begin
                step_n = step + 3'd1;
                if (step < 3'd3) begin
                    ram_ce_n = 1'b1;
                    ram_ad_n = {word_q, next_lane};
                end
                if (step != 3'd0) begin
                    rdata_n[{cap_lane, 3'b000} +: 8] = ram_dout;
                end
                if (step == 3'd4) begin
                    state_n     = DONE;
                    mem_ready_n = 1'b1;
                end
            end
            CPU_WR: begin
                step_n = step + 3'd1;
                if (step < 3'd3) begin
                    ram_ce_n  = wstrb_q[next_lane];
                    ram_wre_n = wstrb_q[next_lane];
                    ram_ad_n  = {word_q, next_lane};
                    ram_din_n = lane_byte(wdata_q, next_lane);
                end else begin
                    state_n     = DONE;
                    mem_ready_n = 1'b1;
                end
            end
            LD_WR: begin
                state_n    = DONE;
                ld_ready_n = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step        <= 3'd0;
            word_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            ram_ce      <= 1'b0;
            ram_wre     <= 1'b0;
            ram_ad      <= '0;
            ram_din     <= '0;
            mem_ready_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state       <= state_n;
            step        <= step_n;
            ram_ce      <= ram_ce_n;
            ram_wre     <= ram_wre_n;
            ram_ad      <= ram_ad_n;
            ram_din     <= ram_din_n;
            mem_ready_q <= mem_ready_n;
            ld_ready_q  <= ld_ready_n;
            rdata_q     <= rdata_n;
            if (gnt_cpu) begin
                word_q  <= bus.mem_addr[ADDR_W-1:2];
                wdata_q <= bus.mem_wdata;
                wstrb_q <= bus.mem_wstrb;
            end
        end
    end

    assign ram_oce       = 1'b1;
    assign busy          = (state != IDLE);
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.ld_ready  = ld_ready_q;

endmodule
